// File: rtl/uart_pkg.sv
// Shared UART types and constants: state encoding, frame sizes, line levels.
// Imported by uart_tx today and by the future uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Controller-to-transmitter link: byte/strobe in, busy and serial line out,
// plus the FSM state for observation.
// Handshake: the transmitter accepts tx_byte_i on any clock edge where
// new_tx_data_i=1 and tx_busy_o=0; requests seen while busy are dropped.
interface uart_tx_if;
  import uart_pkg::*;

  logic [7:0] tx_byte_i;
  logic       new_tx_data_i;
  logic       tx_busy_o;
  logic       tx_o;
  tx_state_e  state_dbg;

  modport master (
    output tx_byte_i,
    output new_tx_data_i,
    input  tx_busy_o,
    input  tx_o,
    input  state_dbg
  );

  modport slave (
    input  tx_byte_i,
    input  new_tx_data_i,
    output tx_busy_o,
    output tx_o,
    output state_dbg
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// clear holds it at zero so the first bit after an accept is full length.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Wrapping on tick realigns every bit boundary, so no drift can build up.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first, idle-high line, fixed divider baud.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  uart_tx_if.slave   tx_if
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e      state_q, state_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           baud_clear;
  logic           baud_tick;
`ifdef UART_TX_PARITY_EN
  logic           parity_q, parity_d;
`endif

  // Counter is parked at zero while idle, which also restarts it on accept.
  assign baud_clear = (state_q == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d   = LINE_IDLE;
        busy_d = 1'b0;
        if (tx_if.new_tx_data_i) begin
          shift_d   = tx_if.tx_byte_i;
          bit_idx_d = 3'd0;
          state_d   = START;
          tx_d      = START_BIT;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(tx_if.tx_byte_i);
`endif
        end
      end

      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = STOP_BIT;
`endif
          end else begin
            // Next data bit is what will sit in shift[0] after the shift.
            tx_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_d = STOP;
          tx_d    = STOP_BIT;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          tx_d    = LINE_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_if.tx_o      = tx_q;
  assign tx_if.tx_busy_o = busy_q;
  assign tx_if.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4: directed cases, random requests,
// a frame-timing reference model and a line decoder with an expected-byte queue.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = FRAME_BITS_8E1;
`else
  localparam int NB = FRAME_BITS_8N1;
`endif
  localparam int FRAME_CYC = NB * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .tx_if   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is a list of line levels, one per bit period; the model just
  // counts cycles since acceptance and looks up which bit period it is in.
  logic [7:0]    exp_q[$];
  int            m_elapsed = -1;
  logic [NB-1:0] m_frame   = '1;

  function automatic logic [NB-1:0] build_frame(input logic [7:0] b);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_elapsed = -1;
      exp_q.delete();
    end else if (m_elapsed < 0) begin
      if (bus.new_tx_data_i) begin
        m_frame   = build_frame(bus.tx_byte_i);
        m_elapsed = 0;
        exp_q.push_back(bus.tx_byte_i);
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == FRAME_CYC) m_elapsed = -1;
    end
  end

  // Cycle-by-cycle line/busy comparison against the model.
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.tx_busy_o), 32'(m_elapsed >= 0));
      check("tx", 32'(bus.tx_o), (m_elapsed < 0) ? 32'd1 : 32'(m_frame[m_elapsed / CPB]));
    end
  end

  // ---------------- line decoder / scoreboard ----------------
  int            rx_cnt  = -1;
  logic          prev_tx = 1'b1;
  logic [NB-1:0] rx_bits = '0;
  logic [7:0]    rx_byte;
  logic [7:0]    exp_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_cnt  = -1;
      prev_tx = 1'b1;
    end else begin
      if (rx_cnt < 0 && prev_tx && !bus.tx_o) rx_cnt = 0;
      if (rx_cnt >= 0) begin
        if (rx_cnt % CPB == CPB / 2) rx_bits[rx_cnt / CPB] = bus.tx_o;
        if (rx_cnt == (NB - 1) * CPB + CPB / 2) begin
          rx_byte = rx_bits[8:1];
          check("rx_start", 32'(rx_bits[0]), 32'(START_BIT));
          check("rx_stop", 32'(rx_bits[NB-1]), 32'(STOP_BIT));
`ifdef UART_TX_PARITY_EN
          check("rx_parity", 32'(rx_bits[9]), 32'(^rx_byte));
`endif
          if (exp_q.size() == 0) begin
            check("rx_unexpected_frame", 32'(rx_byte), 32'hDEAD);
          end else begin
            exp_byte = exp_q.pop_front();
            check("rx_byte", 32'(rx_byte), 32'(exp_byte));
          end
          rx_cnt = -1;
        end else begin
          rx_cnt++;
        end
      end
      prev_tx = bus.tx_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pulse(input logic [7:0] b);
    bus.tx_byte_i     = b;
    bus.new_tx_data_i = 1'b1;
    @(negedge clk);
    bus.new_tx_data_i = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int limit, output int n);
    n = 0;
    while (bus.tx_busy_o !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_timeout", 32'(n >= limit), 32'd0);
  endtask

  // Called on the first busy cycle; samples each bit period at mid-bit.
  task automatic measure_frame(output int len, output logic [10:0] bits);
    len  = 0;
    bits = '0;
    while (bus.tx_busy_o && len < 500) begin
      if (len % CPB == CPB / 2 && len / CPB < 11) bits[len / CPB] = bus.tx_o;
      len++;
      @(negedge clk);
    end
  endtask

  // ---------------- test sequence ----------------
  int         n, len, busy_seen;
  logic [10:0] bits;
  logic        hold;

  initial begin
    bus.tx_byte_i     = 8'h00;
    bus.new_tx_data_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx_o), 32'd1);
    check("rst_busy", 32'(bus.tx_busy_o), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);

    // 0xA5 single pulse
    send_pulse(8'hA5);
    check("a5_busy_rise", 32'(bus.tx_busy_o), 32'd1);
    measure_frame(len, bits);
    check("a5_busy_len", 32'(len), 32'(FRAME_CYC));
`ifdef UART_TX_PARITY_EN
    check("a5_bits", 32'(bits), 32'b10101001010);
`else
    check("a5_bits", 32'(bits[9:0]), 32'b1101001010);
`endif
    repeat (5) @(negedge clk);

    // 0x3C requested mid-frame while 0xFF in flight
    send_pulse(8'hFF);
    repeat (14) @(negedge clk);
    bus.tx_byte_i     = 8'h3C;
    bus.new_tx_data_i = 1'b1;
    @(negedge clk);
    bus.new_tx_data_i = 1'b0;
    bus.tx_byte_i     = 8'h99;
    wait_busy(1'b0, 200, n);
    check("ff_busy_len", 32'(15 + n), 32'(FRAME_CYC));
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.tx_busy_o) busy_seen++;
    end
    check("ff_no_second", 32'(busy_seen), 32'd0);

    // Held level request with 0x00
    bus.tx_byte_i     = 8'h00;
    bus.new_tx_data_i = 1'b1;
    wait_busy(1'b1, 10, n);
    check("hold_accept", 32'(n), 32'd1);
    wait_busy(1'b0, 200, n);
    check("hold_len1", 32'(n), 32'(FRAME_CYC));
    wait_busy(1'b1, 10, n);
    check("hold_gap1", 32'(n), 32'd1);
    wait_busy(1'b0, 200, n);
    check("hold_len2", 32'(n), 32'(FRAME_CYC));
    wait_busy(1'b1, 10, n);
    check("hold_gap2", 32'(n), 32'd1);
    bus.new_tx_data_i = 1'b0;
    wait_busy(1'b0, 200, n);
    check("hold_len3", 32'(n), 32'(FRAME_CYC));
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of a 0x81 frame
    send_pulse(8'h81);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_tx", 32'(bus.tx_o), 32'd1);
    check("areset_busy", 32'(bus.tx_busy_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_pulse(8'h81);
    wait_busy(1'b0, 200, n);
    check("after_reset_len", 32'(n), 32'(FRAME_CYC));
    repeat (5) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    send_pulse(8'h07);
    measure_frame(len, bits);
    check("par07_len", 32'(len), 32'd44);
    check("par07_parity", 32'(bits[9]), 32'd1);
    repeat (5) @(negedge clk);
`endif

    // Random requests: pulses, held levels, byte churn during frames
    hold = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 4) hold = ~hold;
      bus.new_tx_data_i = hold | ($urandom_range(0, 19) == 0);
      bus.tx_byte_i     = 8'($urandom);
    end
    @(negedge clk);
    bus.new_tx_data_i = 1'b0;
    wait_busy(1'b0, 200, n);
    repeat (10) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: 8N1 framing, LSB first, idle-high line.
- Consumes the byte/strobe pair driven by the RAM test controller (tx_byte, new_tx_data) and returns tx_busy to it.
- Sits directly downstream of the controller and drives the FPGA TX pin.
- Baud timing comes from a fixed clock-cycles-per-bit divider; there is no fractional baud generation.

Parameters:
- CLKS_PER_BIT, 434, clk_i cycles per serial bit (50 MHz / 115200). Legal range 2..65535.
- CNT_W, $clog2(CLKS_PER_BIT), baud counter width. Derived; do not override.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- tx_byte_i  input  8  byte to send; sampled only on the accept cycle
- new_tx_data_i  input  1  send request; single-cycle strobe or level, sampled each cycle
- tx_busy_o  output  1  high while a frame is in flight
- tx_o  output  1  serial line, registered

Behaviour:
- Clock and reset: one clock (clk_i). Reset is asynchronous and active-low (rst_n_i).
- Reset values: tx_o=1, tx_busy_o=0, state=IDLE, baud counter=0, bit index=0, shift register=0.
- Reset is honoured mid-frame: the line returns high immediately and any partial frame is dropped.
- States are IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE: tx_o=1, tx_busy_o=0.
  - If new_tx_data_i=1 at edge N, latch tx_byte_i into the shift register and go to START.
  - tx_busy_o=1 and tx_o=0 both from cycle N+1 (one-cycle accept latency).
- START: hold tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: drive shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index.
  - After bit 7 completes, go to STOP (or PARITY).
- STOP: hold tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE and drop tx_busy_o.
- Frame length: tx_busy_o is high for exactly 10*CLKS_PER_BIT cycles (11* with parity).
- Baud counter: counts 0..CLKS_PER_BIT-1. It reloads to 0 on every bit boundary and on accept; no drift accumulates.
- new_tx_data_i while busy: ignored, with no queueing. tx_byte_i changes during a frame have no effect.
- Back-to-back frames: in the first IDLE cycle after STOP, a new request is accepted. This gives a one-cycle minimum idle-high gap between frames.
- Held level request: retransmits the same byte continuously, one frame per 10*CLKS_PER_BIT+1 cycles.
- tx_o is driven only from a flop; it never glitches.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the latched byte, computed at accept) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1; busy lasts 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; 8N1 only.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - DATA_BITS=8
  - FRAME_BITS_8N1=10, FRAME_BITS_8E1=11
  - line constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1
- One sub-module: uart_baud_counter (clk, rst_n, clear, tick when count==CLKS_PER_BIT-1).
  - The same sub-module is reused by the future uart_rx.
- FSM, shift register and bit index stay in uart_tx.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset held low, then released: tx_o=1 and tx_busy_o=0 for 20 idle cycles.
- Pulse new_tx_data_i with tx_byte_i=0xA5:
  - busy rises the next cycle and stays high for 40 cycles.
  - tx_o sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1.
- Request 0x3C while busy mid-frame with 0xFF:
  - only 0xFF frame appears; no second frame is sent.
  - busy falls at cycle 40.
- Hold new_tx_data_i high with 0x00:
  - frames repeat with a single idle-high cycle between them.
  - each frame is start, eight 0 bits, stop.
- Assert rst_n_i low at cycle 15 of a 0x81 frame: tx_o=1 and busy=0 asynchronously, before the next edge. After release, a fresh 0x81 request transmits cleanly.
- UART_TX_PARITY_EN defined, byte 0x07: parity bit=1, busy=44 cycles. With CLKS_PER_BIT=434, bit time is 434 cycles ±0.
